// File: rtl/timing_sequence_gen.sv
// timing_sequence_gen: micro-step sequence counter with one-hot timing decode.
// Supports clear / parallel load / increment (in that priority), wrap or
// saturate at MAX_COUNT, a one-cycle wrap pulse and a sticky error flag that
// records command conflicts and out-of-range loads.
module timing_sequence_gen #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 15,
    parameter bit WRAP      = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc,
    input  logic                 ld,
    input  logic [WIDTH-1:0]     ld_val,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     seq,
    output logic [MAX_COUNT:0]   t,
    output logic                 tc,
    output logic                 wrap_pulse,
    output logic                 err
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

    logic [WIDTH-1:0] seq_r;
    logic [WIDTH-1:0] next_seq_s;
    logic             wrap_r;
    logic             next_wrap_s;
    logic             err_r;
    logic             next_err_s;
    logic             conflict_s;
    logic             ld_bad_s;

    // Detect two or more commands asserted on the same edge.
    always_comb begin
        conflict_s = (clr && ld) || (clr && inc) || (ld && inc);
    end

    // Next count and wrap pulse: clr beats ld beats inc beats hold.
    always_comb begin
        next_seq_s  = seq_r;
        next_wrap_s = 1'b0;
        ld_bad_s    = 1'b0;
        if (clr) begin
            next_seq_s = ZERO_V;
        end else if (ld) begin
            if (ld_val <= MAX_V) begin
                next_seq_s = ld_val;
            end else begin
                // Out-of-range load clamps to the terminal count and flags it.
                next_seq_s = MAX_V;
                ld_bad_s   = 1'b1;
            end
        end else if (inc) begin
            if (seq_r < MAX_V) begin
                next_seq_s = seq_r + ONE_V;
            end else if (WRAP) begin
                next_seq_s  = ZERO_V;
                next_wrap_s = 1'b1;
            end else begin
                next_seq_s = seq_r;
            end
        end else begin
            next_seq_s = seq_r;
        end
    end

    // Sticky error: a new error on the same edge overrides err_clr.
    always_comb begin
        next_err_s = err_r;
        if (conflict_s || ld_bad_s) begin
            next_err_s = 1'b1;
        end else if (err_clr) begin
            next_err_s = 1'b0;
        end else begin
            next_err_s = err_r;
        end
    end

    // State registers with asynchronous reset to count 0, no pulse, no error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_r  <= ZERO_V;
            wrap_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            seq_r  <= next_seq_s;
            wrap_r <= next_wrap_s;
            err_r  <= next_err_s;
        end
    end

    // One-hot timing decode straight from the count register.
    always_comb begin
        t = {(MAX_COUNT+1){1'b0}};
        for (int i = 0; i <= MAX_COUNT; i++) begin
            t[i] = (seq_r == WIDTH'(i));
        end
    end

    // Terminal-count flag is a pure decode of the count register.
    always_comb begin
        tc = (seq_r == MAX_V);
    end

    // Drive registered outputs.
    always_comb begin
        seq        = seq_r;
        wrap_pulse = wrap_r;
        err        = err_r;
    end

endmodule

// File: tb/tb_timing_sequence_gen.sv
// Bench for timing_sequence_gen: two instances (wrap at 15, saturate at 9)
// driven with identical commands; a reference model pushes expected state
// into a queue and a separate monitor pops and compares every cycle.
module tb_timing_sequence_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       inc = 1'b0;
    logic       ld = 1'b0;
    logic [3:0] ld_val = 4'd0;
    logic       err_clr = 1'b0;

    logic [3:0]  seq_a, seq_b;
    logic [15:0] t_a;
    logic [9:0]  t_b;
    logic        tc_a, tc_b, wrap_a, wrap_b, err_a, err_b;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] seq0;
        logic [7:0] seq1;
        logic       w0;
        logic       w1;
        logic       e0;
        logic       e1;
    } exp_t;

    exp_t exp_q[$];

    // Reference state, index 0: MAX=15 wrapping; index 1: MAX=9 saturating.
    int m_seq[2];
    bit m_wrap[2];
    bit m_err[2];

    timing_sequence_gen #(.WIDTH(4), .MAX_COUNT(15), .WRAP(1'b1)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .inc(inc), .ld(ld), .ld_val(ld_val),
        .err_clr(err_clr), .seq(seq_a), .t(t_a), .tc(tc_a),
        .wrap_pulse(wrap_a), .err(err_a)
    );

    timing_sequence_gen #(.WIDTH(4), .MAX_COUNT(9), .WRAP(1'b0)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .inc(inc), .ld(ld), .ld_val(ld_val),
        .err_clr(err_clr), .seq(seq_b), .t(t_b), .tc(tc_b),
        .wrap_pulse(wrap_b), .err(err_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_seq[k]  = 0;
            m_wrap[k] = 1'b0;
            m_err[k]  = 1'b0;
        end
    endfunction

    function automatic void model_step(input int k, input bit c, input bit l,
                                       input bit i, input int v, input bit ec);
        int mx;
        bit wr;
        bit new_err;
        mx      = (k == 0) ? 15 : 9;
        wr      = (k == 0);
        new_err = (int'(c) + int'(l) + int'(i)) >= 2;
        m_wrap[k] = 1'b0;
        if (c) begin
            m_seq[k] = 0;
        end else if (l) begin
            if (v <= mx) m_seq[k] = v;
            else begin
                m_seq[k] = mx;
                new_err  = 1'b1;
            end
        end else if (i) begin
            if (m_seq[k] < mx) m_seq[k] = m_seq[k] + 1;
            else if (wr) begin
                m_seq[k]  = 0;
                m_wrap[k] = 1'b1;
            end
        end
        if (new_err) m_err[k] = 1'b1;
        else if (ec) m_err[k] = 1'b0;
    endfunction

    // Drive one command cycle and queue the expected response.
    task automatic cycle(input bit c, input bit l, input bit i, input int v, input bit ec);
        exp_t e;
        @(negedge clk);
        clr = c; ld = l; inc = i; ld_val = 4'(v); err_clr = ec;
        model_step(0, c, l, i, v, ec);
        model_step(1, c, l, i, v, ec);
        e.seq0 = 8'(m_seq[0]);
        e.seq1 = 8'(m_seq[1]);
        e.w0   = m_wrap[0];
        e.w1   = m_wrap[1];
        e.e0   = m_err[0];
        e.e1   = m_err[1];
        exp_q.push_back(e);
    endtask

    // Monitor: after each edge pop an expectation and compare both instances.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("seq_a",  int'(seq_a),  int'(e.seq0));
            check("t_a",    int'(t_a),    1 << int'(e.seq0));
            check("tc_a",   int'(tc_a),   int'(e.seq0 == 8'd15));
            check("wrap_a", int'(wrap_a), int'(e.w0));
            check("err_a",  int'(err_a),  int'(e.e0));
            check("seq_b",  int'(seq_b),  int'(e.seq1));
            check("t_b",    int'(t_b),    1 << int'(e.seq1));
            check("tc_b",   int'(tc_b),   int'(e.seq1 == 8'd9));
            check("wrap_b", int'(wrap_b), int'(e.w1));
            check("err_b",  int'(err_b),  int'(e.e1));
            check("onehot_a", int'($onehot(t_a)), 1);
            check("onehot_b", int'($onehot(t_b)), 1);
            check("range_b",  int'(seq_b <= 4'd9), 1);
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        model_reset();
        // Reset state while rst held.
        @(negedge clk);
        #1;
        check("rst_seq_a", int'(seq_a), 0);
        check("rst_t_a",   int'(t_a),   1);
        check("rst_tc_a",  int'(tc_a),  0);
        check("rst_err_a", int'(err_a), 0);
        check("rst_wrap_a", int'(wrap_a), 0);
        check("rst_t_b",   int'(t_b),   1);
        @(negedge clk);
        rst = 1'b0;

        // Load 7 with a simultaneous inc: seq=7 and err set, then async reset.
        cycle(1'b0, 1'b1, 1'b1, 7, 1'b0);
        @(posedge clk);
        #3;
        clr = 1'b0; ld = 1'b0; inc = 1'b0; err_clr = 1'b0;
        check("pre_rst_seq_a", int'(seq_a), 7);
        rst = 1'b1;
        #1;
        check("async_seq_a", int'(seq_a), 0);
        check("async_t_a",   int'(t_a),   1);
        check("async_err_a", int'(err_a), 0);
        check("async_seq_b", int'(seq_b), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Wrap / saturate: 16 incs (wrap instance returns to 0, saturating stays 9).
        for (int n = 0; n < 16; n++) cycle(1'b0, 1'b0, 1'b1, 0, 1'b0);
        // 12 incs from 0 after a clear.
        cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
        for (int n = 0; n < 12; n++) cycle(1'b0, 1'b0, 1'b1, 0, 1'b0);

        // Loads: in range, then out of range for MAX=9.
        cycle(1'b0, 1'b1, 1'b0, 5, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 12, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b1);

        // Conflicts and err_clr interaction.
        cycle(1'b0, 1'b1, 1'b0, 3, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 2, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b1);

        // Randomised command mix.
        for (int n = 0; n < 10000; n++) begin
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
                  $urandom_range(0, 7) == 0);
        end

        @(negedge clk);
        clr = 1'b0; ld = 1'b0; inc = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
